sram_req_arbiter: RTL and testbench

//  Single-port SRAM front end shared by the bloom-filter marker (client B) and the shift engine (client S).

---
 rtl/sram_arb_pkg.sv | 25 ++
 rtl/rr_grant4.sv | 23 ++
 rtl/sram_req_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM request arbiter: source/client indices,
// read-return tag layout, turnaround FSM states and a one-hot decode helper.
package sram_arb_pkg;

    localparam int SRC_B_RD = 0;
    localparam int SRC_B_WR = 1;
    localparam int SRC_S_RD = 2;
    localparam int SRC_S_WR = 3;

    localparam logic CLI_B = 1'b0;
    localparam logic CLI_S = 1'b1;

    // Read-return tag entry: {valid, client}
    localparam int TAG_W = 2;

    typedef enum logic {
        ST_ISSUE  = 1'b0,
        ST_BUBBLE = 1'b1
    } arb_state_t;

    function automatic logic [1:0] oh4_to_idx(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/rr_grant4.sv
// Combinational 4-way round-robin picker: first pending source at or after
// the pointer wins; state (pointer) is owned by the parent.
module rr_grant4 (
    input  logic [3:0] pending,
    input  logic [1:0] ptr,
    output logic [3:0] grant
);

    logic [1:0] idx;

    // Walk from farthest to nearest so the nearest pending source overrides.
    always_comb begin
        grant = '0;
        idx   = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (pending[idx]) begin
                grant = 4'b0001 << idx;
            end
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Single-port SRAM front end arbitrating B/S read and write requests round-robin.
// Optional SRAM_ARB_TURNAROUND_EN inserts an idle cycle on read<->write direction changes.
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 72,
    parameter int READ_LATENCY    = 3
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       b_rd_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] b_rd_addr,
    output logic                       b_rd_ack,
    output logic                       b_rd_vld,
    output logic [SRAM_DATA_WIDTH-1:0] b_rd_data,
    input  logic                       b_wr_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] b_wr_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] b_wr_data,
    output logic                       b_wr_ack,
    output logic                       b_enable,

    input  logic                       s_rd_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] s_rd_addr,
    output logic                       s_rd_ack,
    output logic                       s_rd_vld,
    output logic [SRAM_DATA_WIDTH-1:0] s_rd_data,
    input  logic                       s_wr_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] s_wr_addr,
    input  logic [SRAM_DATA_WIDTH-1:0] s_wr_data,
    output logic                       s_wr_ack,
    output logic                       s_enable,

    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
    output logic                       sram_we,
    output logic                       sram_rd_en,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data
);

    localparam int AW = SRAM_ADDR_WIDTH;
    localparam int DW = SRAM_DATA_WIDTH;

    logic [3:0]    req;
    logic [3:0]    pending;
    logic [AW-1:0] req_addr [4];
    logic [AW-1:0] addr_q   [4];
    logic [DW-1:0] b_wr_data_q;
    logic [DW-1:0] s_wr_data_q;

    logic [3:0]    grant;
    logic [1:0]    ptr;
    logic [1:0]    win;
    logic          issue;
    arb_state_t    state, state_nxt;

    logic [3:0]    ack_q;
    logic          rd_cli_p0;
    logic [TAG_W-1:0] rd_tag_p [READ_LATENCY];
    logic          tag_vld;
    logic          tag_cli;

    assign req = {s_wr_req, s_rd_req, b_wr_req, b_rd_req};
    assign req_addr[SRC_B_RD] = b_rd_addr;
    assign req_addr[SRC_B_WR] = b_wr_addr;
    assign req_addr[SRC_S_RD] = s_rd_addr;
    assign req_addr[SRC_S_WR] = s_wr_addr;

    // Request slots: a req only lands in an empty slot; the winner clears at issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (issue && win == 2'(i)) begin
                    pending[i] <= 1'b0;
                end else if (req[i]) begin
                    pending[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (req[i] && !pending[i]) begin
                addr_q[i] <= req_addr[i];
            end
        end
        if (b_wr_req && !pending[SRC_B_WR]) b_wr_data_q <= b_wr_data;
        if (s_wr_req && !pending[SRC_S_WR]) s_wr_data_q <= s_wr_data;
    end

    rr_grant4 u_rr_grant4 (
        .pending (pending),
        .ptr     (ptr),
        .grant   (grant)
    );

    assign win = oh4_to_idx(grant);

`ifdef SRAM_ARB_TURNAROUND_EN
    // A grant opposite in direction to the strobe on the bus now waits one cycle.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            ST_ISSUE: begin
                if (|grant) begin
                    if ((win[0] && sram_rd_en) || (!win[0] && sram_we)) begin
                        state_nxt = ST_BUBBLE;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            ST_BUBBLE: begin
                issue     = |grant;
                state_nxt = ST_ISSUE;
            end
            default: state_nxt = ST_ISSUE;
        endcase
    end
`else
    always_comb begin
        state_nxt = ST_ISSUE;
        issue     = (|grant) && (state == ST_ISSUE);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ISSUE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue stage: SRAM strobes and client acks are registered together.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr          <= 2'd0;
            sram_we      <= 1'b0;
            sram_rd_en   <= 1'b0;
            sram_addr    <= '0;
            sram_wr_data <= '0;
            ack_q        <= '0;
            rd_cli_p0    <= 1'b0;
        end else begin
            sram_we    <= issue & win[0];
            sram_rd_en <= issue & ~win[0];
            ack_q      <= issue ? grant : 4'b0000;
            rd_cli_p0  <= win[1];
            if (issue) begin
                ptr       <= win + 2'd1;
                sram_addr <= addr_q[win];
                if (win[0]) begin
                    sram_wr_data <= win[1] ? s_wr_data_q : b_wr_data_q;
                end
            end
        end
    end

    assign b_rd_ack = ack_q[SRC_B_RD];
    assign b_wr_ack = ack_q[SRC_B_WR];
    assign s_rd_ack = ack_q[SRC_S_RD];
    assign s_wr_ack = ack_q[SRC_S_WR];

    // Tag stages: {valid, client} follows each read for READ_LATENCY cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_tag_p[i] <= '0;
            end
        end else begin
            rd_tag_p[0] <= {sram_rd_en, rd_cli_p0};
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_tag_p[i] <= rd_tag_p[i-1];
            end
        end
    end

    assign tag_vld = rd_tag_p[READ_LATENCY-1][1];
    assign tag_cli = rd_tag_p[READ_LATENCY-1][0];

    // Return stage: capture SRAM data for the client at tag exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_rd_vld  <= 1'b0;
            s_rd_vld  <= 1'b0;
            b_rd_data <= '0;
            s_rd_data <= '0;
        end else begin
            b_rd_vld <= tag_vld && (tag_cli == CLI_B);
            s_rd_vld <= tag_vld && (tag_cli == CLI_S);
            if (tag_vld && tag_cli == CLI_B) b_rd_data <= sram_rd_data;
            if (tag_vld && tag_cli == CLI_S) s_rd_data <= sram_rd_data;
        end
    end

    assign b_enable = !pending[SRC_B_RD];
    assign s_enable = !pending[SRC_S_RD];

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter with a behavioural SRAM returning
// address-tagged data READ_LATENCY cycles after each read strobe.
`timescale 1ns/1ps
module tb_sram_req_arbiter;

    localparam int AW = 19;
    localparam int DW = 72;
    localparam int RL = 3;
`ifdef SRAM_ARB_TURNAROUND_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          b_rd_req = 0, b_wr_req = 0, s_rd_req = 0, s_wr_req = 0;
    logic [AW-1:0] b_rd_addr = '0, b_wr_addr = '0, s_rd_addr = '0, s_wr_addr = '0;
    logic [DW-1:0] b_wr_data = '0, s_wr_data = '0;
    logic          b_rd_ack, b_rd_vld, b_wr_ack, b_enable;
    logic          s_rd_ack, s_rd_vld, s_wr_ack, s_enable;
    logic [DW-1:0] b_rd_data, s_rd_data;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wr_data, sram_rd_data;
    logic          sram_we, sram_rd_en;

    always #5 clk = ~clk;

    sram_req_arbiter #(
        .SRAM_ADDR_WIDTH (AW),
        .SRAM_DATA_WIDTH (DW),
        .READ_LATENCY    (RL)
    ) dut (
        .clk (clk), .reset (reset),
        .b_rd_req (b_rd_req), .b_rd_addr (b_rd_addr), .b_rd_ack (b_rd_ack),
        .b_rd_vld (b_rd_vld), .b_rd_data (b_rd_data),
        .b_wr_req (b_wr_req), .b_wr_addr (b_wr_addr), .b_wr_data (b_wr_data),
        .b_wr_ack (b_wr_ack), .b_enable (b_enable),
        .s_rd_req (s_rd_req), .s_rd_addr (s_rd_addr), .s_rd_ack (s_rd_ack),
        .s_rd_vld (s_rd_vld), .s_rd_data (s_rd_data),
        .s_wr_req (s_wr_req), .s_wr_addr (s_wr_addr), .s_wr_data (s_wr_data),
        .s_wr_ack (s_wr_ack), .s_enable (s_enable),
        .sram_addr (sram_addr), .sram_wr_data (sram_wr_data),
        .sram_we (sram_we), .sram_rd_en (sram_rd_en), .sram_rd_data (sram_rd_data)
    );

    function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
        return {8'hA5, 45'h0, a};
    endfunction

    // SRAM model: data valid RL cycles after the read strobe cycle.
    logic [RL-1:0] pv = '0;
    logic [AW-1:0] pa [RL];
    always @(posedge clk) begin
        pv    <= {pv[RL-2:0], sram_rd_en};
        pa[0] <= sram_addr;
        for (int i = 1; i < RL; i++) pa[i] <= pa[i-1];
    end
    assign sram_rd_data = pv[RL-1] ? fdata(pa[RL-1]) : '1;

    int n_chk = 0;
    int n_err = 0;
    int cyc;
    int ack_cnt [4];
    int ack_cyc [4];
    logic [AW-1:0] ack_addr [4];
    int vld_cnt [2];
    int vld_cyc [2];
    logic [DW-1:0] vld_data [2];
    int both_cnt;
    int en_low_last [2];
    int st_cyc_q [$];
    logic st_we_q [$];
    logic [DW-1:0] st_data_q [$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        cyc = 0;
        both_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            ack_cnt[i] = 0; ack_cyc[i] = -1; ack_addr[i] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            vld_cnt[i] = 0; vld_cyc[i] = -1; vld_data[i] = '0; en_low_last[i] = 0;
        end
        st_cyc_q.delete();
        st_we_q.delete();
        st_data_q.delete();
    endtask

    task automatic tick();
        logic [3:0] acks;
        @(posedge clk);
        #1;
        cyc++;
        acks = {s_wr_ack, s_rd_ack, b_wr_ack, b_rd_ack};
        for (int i = 0; i < 4; i++) begin
            if (acks[i]) begin
                ack_cnt[i]++; ack_cyc[i] = cyc; ack_addr[i] = sram_addr;
            end
        end
        if (b_rd_vld) begin vld_cnt[0]++; vld_cyc[0] = cyc; vld_data[0] = b_rd_data; end
        if (s_rd_vld) begin vld_cnt[1]++; vld_cyc[1] = cyc; vld_data[1] = s_rd_data; end
        if (sram_we && sram_rd_en) both_cnt++;
        if (sram_we || sram_rd_en) begin
            st_cyc_q.push_back(cyc);
            st_we_q.push_back(sram_we);
            st_data_q.push_back(sram_wr_data);
        end
        if (!b_enable) en_low_last[0] = cyc;
        if (!s_enable) en_low_last[1] = cyc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        clear_log();
        do_reset();

        check("rst_we", DW'(sram_we), DW'(0));
        check("rst_rd_en", DW'(sram_rd_en), DW'(0));
        check("rst_addr", DW'(sram_addr), DW'(0));
        check("rst_wr_data", sram_wr_data, '0);
        check("rst_acks", DW'({b_rd_ack, b_wr_ack, s_rd_ack, s_wr_ack}), DW'(0));
        check("rst_vlds", DW'({b_rd_vld, s_rd_vld}), DW'(0));
        check("rst_rd_data", b_rd_data | s_rd_data, '0);
        check("rst_enables", DW'({b_enable, s_enable}), DW'(2'b11));

        // 1: single S read
        clear_log();
        s_rd_req = 1; s_rd_addr = 19'h00010;
        tick();
        s_rd_req = 0;
        check("t1_s_en_pending", DW'(s_enable), DW'(0));
        repeat (9) tick();
        check("t1_ack_cyc", DW'(ack_cyc[2]), DW'(2));
        check("t1_ack_cnt", DW'(ack_cnt[2]), DW'(1));
        check("t1_ack_addr", DW'(ack_addr[2]), DW'(19'h00010));
        check("t1_vld_cyc", DW'(vld_cyc[1]), DW'(6));
        check("t1_vld_cnt", DW'(vld_cnt[1]), DW'(1));
        check("t1_vld_data", vld_data[1], fdata(19'h00010));
        check("t1_data_held", s_rd_data, fdata(19'h00010));
        check("t1_b_silent", DW'(ack_cnt[0] + ack_cnt[1] + vld_cnt[0]), DW'(0));
        check("t1_s_en_free", DW'(s_enable), DW'(1));

        // 2: all four sources in one cycle
        do_reset();
        clear_log();
        b_rd_req = 1; b_rd_addr = 19'h1;
        b_wr_req = 1; b_wr_addr = 19'h2; b_wr_data = 72'h11_2233_4455_6677_8899;
        s_rd_req = 1; s_rd_addr = 19'h3;
        s_wr_req = 1; s_wr_addr = 19'h4; s_wr_data = 72'hEE_DDCC_BBAA_9988_7766;
        tick();
        {b_rd_req, b_wr_req, s_rd_req, s_wr_req} = 4'b0000;
        repeat (14) tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_ack_cyc%0d", i), DW'(ack_cyc[i]), DW'(2 + GAP * i));
            check($sformatf("t2_ack_addr%0d", i), DW'(ack_addr[i]), DW'(i + 1));
        end
        check("t2_both", DW'(both_cnt), DW'(0));
        check("t2_strobes", DW'(st_cyc_q.size()), DW'(4));
        if (st_cyc_q.size() == 4) begin
            check("t2_b_wdata", st_data_q[1], 72'h11_2233_4455_6677_8899);
            check("t2_s_wdata", st_data_q[3], 72'hEE_DDCC_BBAA_9988_7766);
        end
        check("t2_b_vld_cyc", DW'(vld_cyc[0]), DW'(6));
        check("t2_b_vld_data", vld_data[0], fdata(19'h1));
        check("t2_s_vld_cyc", DW'(vld_cyc[1]), DW'(2 + 2 * GAP + 4));
        check("t2_s_vld_data", vld_data[1], fdata(19'h3));

        // 3: S read re-pulsed with a new address while still pending
        do_reset();
        clear_log();
        b_rd_req = 1; b_rd_addr = 19'h00100;
        b_wr_req = 1; b_wr_addr = 19'h00200;
        s_rd_req = 1; s_rd_addr = 19'h0AAAA;
        tick();
        {b_rd_req, b_wr_req, s_rd_req} = 3'b000;
        tick();
        s_rd_req = 1; s_rd_addr = 19'h05555;
        tick();
        s_rd_req = 0;
        repeat (12) tick();
        check("t3_s_rd_cnt", DW'(ack_cnt[2]), DW'(1));
        check("t3_ack_cyc", DW'(ack_cyc[2]), DW'(2 + 2 * GAP));
        check("t3_ack_addr", DW'(ack_addr[2]), DW'(19'h0AAAA));
        check("t3_en_low_last", DW'(en_low_last[1]), DW'(1 + 2 * GAP));
        check("t3_vld_cnt", DW'(vld_cnt[1]), DW'(1));
        check("t3_vld_data", vld_data[1], fdata(19'h0AAAA));

        // 4: read followed by write, turnaround spacing
        do_reset();
        clear_log();
        b_rd_req = 1; b_rd_addr = 19'h00111;
        s_wr_req = 1; s_wr_addr = 19'h00222; s_wr_data = 72'h5A;
        tick();
        {b_rd_req, s_wr_req} = 2'b00;
        repeat (6) tick();
        check("t4_rd_cyc", DW'(ack_cyc[0]), DW'(2));
        check("t4_wr_cyc", DW'(ack_cyc[3]), DW'(2 + GAP));
        check("t4_strobes", DW'(st_cyc_q.size()), DW'(2));
        if (st_cyc_q.size() == 2) begin
            check("t4_gap", DW'(st_cyc_q[1] - st_cyc_q[0]), DW'(GAP));
            check("t4_second_is_wr", DW'(st_we_q[1]), DW'(1));
        end
        check("t4_both", DW'(both_cnt), DW'(0));

        // 5: reset while a read is in flight
        clear_log();
        s_rd_req = 1; s_rd_addr = 19'h00333;
        tick();
        s_rd_req = 0;
        tick();
        check("t5_ack", DW'(s_rd_ack), DW'(1));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_rd_en", DW'(sram_rd_en), DW'(0));
        check("t5_rst_addr", DW'(sram_addr), DW'(0));
        check("t5_rst_b_data", b_rd_data, '0);
        check("t5_rst_acks", DW'({b_rd_ack, b_wr_ack, s_rd_ack, s_wr_ack, sram_we}), DW'(0));
        check("t5_rst_enables", DW'({b_enable, s_enable}), DW'(2'b11));
        repeat (8) tick();
        check("t5_no_vld", DW'(vld_cnt[0] + vld_cnt[1]), DW'(0));

        clear_log();
        s_rd_req = 1; s_rd_addr = 19'h7FFFF;
        tick();
        s_rd_req = 0;
        repeat (8) tick();
        check("t5_new_ack_cyc", DW'(ack_cyc[2]), DW'(2));
        check("t5_new_addr", DW'(ack_addr[2]), DW'(19'h7FFFF));
        check("t5_new_vld_cyc", DW'(vld_cyc[1]), DW'(6));
        check("t5_new_vld_data", vld_data[1], fdata(19'h7FFFF));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
